secuenciador_mux: RTL and testbench
===================================

Name: secuenciador_mux

Overview:
- Upstream control stage for the 4:1 reset/set output multiplexer.
- Generates `selector`, `rs` and `set` for that mux.
- Scans the enabled input channels round-robin and holds each channel for a programmable dwell time.
- Applies forced-clear / forced-set overrides on request. Reports sweep completion and status to the surrounding controller.

Parameters:
- DWELL_W, 4, width of the dwell-time input and the internal dwell counter.
- NCH, 4, number of mux channels; fixed at 4, matches the 2-bit selector.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a scan from IDLE.
- stop  input  1  single-cycle pulse; aborts the scan and returns to IDLE.
- mascara  input  4  channel-enable mask; bit i enables channel i. Latched on an accepted start.
- dwell  input  DWELL_W  cycles per channel. Latched on an accepted start; value 0 is treated as 1.
- cmd_clr  input  1  level; forces mux output to 0 while high.
- cmd_set  input  1  level; forces mux output to all ones while high.
- selector  output  2  registered channel select to the mux.
- rs  output  1  registered; 1 = mux output cleared.
- set  output  1  registered; 1 = mux output all ones, valid only when rs=0.
- canal_valido  output  1  one-cycle pulse on the first cycle of each channel dwell.
- vuelta_done  output  1  one-cycle pulse when the scan wraps past the highest enabled channel.
- ocupado  output  1  high in SCAN or FORCE.
- err_mask  output  1  one-cycle pulse when start is rejected because mascara = 0.

Behaviour:
- All outputs are registered. A change on any input is visible on the outputs one cycle later.
- Reset values: selector=0, rs=1, set=0, canal_valido=0, vuelta_done=0, ocupado=0, err_mask=0; state=IDLE; dwell counter=0; latched mask=0.
- States:
  - IDLE: rs=1, set=0, selector=0, ocupado=0.
  - SCAN: rs=0, set=0, selector=current channel, ocupado=1.
  - FORCE: selector held, ocupado=1, counter frozen. rs=cmd_clr. set=cmd_set & ~cmd_clr, so clear wins, matching the mux's rs-over-set priority.
- IDLE->SCAN: requires start=1, stop=0 and mascara!=0.
  - Latch mascara and dwell.
  - Next cycle: selector = lowest enabled channel, rs=0, canal_valido=1.
  - Dwell counter loads max(dwell,1).
- IDLE with start=1 and mascara=0: stay in IDLE; err_mask=1 for one cycle.
- SCAN, per-cycle update: counter decrements by 1.
- SCAN, dwell expiry (counter=1 in the current cycle):
  - Next cycle: selector = next enabled channel above the current one, wrapping 3->0 and skipping disabled channels.
  - Counter reloads; canal_valido=1.
  - If the new index is <= the old index, vuelta_done=1 in the same cycle.
  - Single enabled channel: selector unchanged; canal_valido and vuelta_done pulse every dwell period.
- SCAN->FORCE: on (cmd_clr | cmd_set).
- FORCE->SCAN: when both commands are low.
  - rs/set return to 0 next cycle; the counter resumes from its frozen value.
  - No canal_valido pulse on resume.
- stop in SCAN or FORCE: next cycle returns to IDLE with reset-value outputs.
- Priority order: reset > stop > cmd_clr/cmd_set > dwell expiry > start.
- start while ocupado=1 is ignored. The mask and dwell latched at start are used for the whole scan.
- cmd_clr/cmd_set in IDLE are ignored (output already cleared).
- Reset mid-scan: next cycle outputs equal reset values; no pulses are emitted.
- Dwell counter is DWELL_W bits wide; maximum dwell is 2^DWELL_W - 1 cycles.

Decomposition:
- Shared header holds:
  - state encodings: ST_IDLE=2'd0, ST_SCAN=2'd1, ST_FORCE=2'd2;
  - NCH=4.
- One combinational sub-module, buscar_siguiente:
  - inputs: mask[3:0], current index[1:0];
  - outputs: next enabled index with wrap, and a wrap flag.
- Also used for the first-channel search by passing current index = 3.

Test Plan:
- Reset, then idle 5 cycles -> selector=0, rs=1, set=0, ocupado=0, no pulses.
- mascara=4'b1111, dwell=2, start -> selector sequence 0,0,1,1,2,2,3,3,0; canal_valido every 2 cycles; vuelta_done on the cycle selector returns to 0.
- mascara=4'b1010, dwell=0 -> selector alternates 1,3,1,3 each cycle; vuelta_done on every return to 1.
- During SCAN with dwell=3 on channel 1 at counter=2, cmd_set high 4 cycles -> rs=0, set=1 and selector=1 for 4 cycles; then set=0 and channel 1 is held 2 more cycles. cmd_clr and cmd_set both high -> rs=1, set=0.
- start with mascara=0 -> err_mask one pulse, stays IDLE. start and stop in the same cycle from IDLE -> stays IDLE.
- stop mid-scan on channel 2 -> next cycle rs=1, selector=0, ocupado=0. Synchronous reset mid-FORCE -> all reset values next cycle.

Source files
------------

// File: rtl/secuenciador_mux_pkg.sv
// Shared encodings for the round-robin channel sequencer that drives the 4:1 rs/set mux.
package secuenciador_mux_pkg;

  localparam int NCH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FORCE = 2'd2
  } estado_t;

endpackage

// File: rtl/secuenciador_mux_buscar_siguiente.sv
// Finds the next enabled channel strictly above idx, wrapping 3->0.
// wrap is set when the result is not above idx, i.e. the sweep has turned over.
module secuenciador_mux_buscar_siguiente
  import secuenciador_mux_pkg::*;
(
  input  logic [NCH-1:0] mask,
  input  logic [1:0]     idx,
  output logic [1:0]     nxt,
  output logic           wrap
);

  logic       found;
  logic [1:0] cand;

  always_comb begin
    nxt   = idx;
    found = 1'b0;
    cand  = idx;
    // k = NCH lands back on idx, so a single enabled channel selects itself
    for (int k = 1; k <= NCH; k++) begin
      cand = idx + k[1:0];
      if (!found && mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    wrap = (nxt <= idx);
  end

endmodule

// File: rtl/secuenciador_mux.sv
// Round-robin channel sequencer with per-channel dwell timer and forced clear/set override.
//   state    | meaning
//   ST_IDLE  | mux cleared (rs=1), selector parked at 0, waiting for start
//   ST_SCAN  | stepping through enabled channels, dwell down-counter running
//   ST_FORCE | cmd_clr/cmd_set override active, selector and counter frozen
module secuenciador_mux
  import secuenciador_mux_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [NCH-1:0]     mascara,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               cmd_clr,
  input  logic               cmd_set,
  output logic [1:0]         selector,
  output logic               rs,
  output logic               set,
  output logic               canal_valido,
  output logic               vuelta_done,
  output logic               ocupado,
  output logic               err_mask
);

  estado_t            state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [1:0]         sel_q, sel_d;
  logic               rs_q, rs_d;
  logic               set_q, set_d;
  logic               cv_q, cv_d;
  logic               vd_q, vd_d;
  logic               ocup_q, ocup_d;
  logic               err_q, err_d;

  logic [NCH-1:0]     srch_mask;
  logic [1:0]         srch_idx;
  logic [1:0]         srch_nxt;
  logic               srch_wrap;
  logic [DWELL_W-1:0] dwell_eff;
  logic               force_req;

  // In IDLE the searcher starts from 3 so the first hit is the lowest enabled channel
  assign srch_mask = (state_q == ST_IDLE) ? mascara : mask_q;
  assign srch_idx  = (state_q == ST_IDLE) ? 2'd3 : sel_q;
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign force_req = cmd_clr | cmd_set;

  secuenciador_mux_buscar_siguiente u_buscar (
    .mask (srch_mask),
    .idx  (srch_idx),
    .nxt  (srch_nxt),
    .wrap (srch_wrap)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    rs_d    = rs_q;
    set_d   = set_q;
    cv_d    = 1'b0;
    vd_d    = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        rs_d  = 1'b1;
        set_d = 1'b0;
        sel_d = 2'd0;
        if (start && !stop) begin
          if (mascara != '0) begin
            state_d = ST_SCAN;
            mask_d  = mascara;
            dwell_d = dwell_eff;
            cnt_d   = dwell_eff;
            sel_d   = srch_nxt;
            rs_d    = 1'b0;
            cv_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SCAN, ST_FORCE: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          mask_d  = '0;
          sel_d   = 2'd0;
          rs_d    = 1'b1;
          set_d   = 1'b0;
        end else if (force_req) begin
          state_d = ST_FORCE;
          rs_d    = cmd_clr;
          set_d   = cmd_set & ~cmd_clr;
        end else if (state_q == ST_FORCE) begin
          // resume with the frozen count; no channel-start pulse
          state_d = ST_SCAN;
          rs_d    = 1'b0;
          set_d   = 1'b0;
        end else if (cnt_q <= DWELL_W'(1)) begin
          sel_d = srch_nxt;
          cnt_d = dwell_q;
          cv_d  = 1'b1;
          vd_d  = srch_wrap;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 2'd0;
        rs_d    = 1'b1;
        set_d   = 1'b0;
      end
    endcase

    ocup_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      sel_q   <= 2'd0;
      rs_q    <= 1'b1;
      set_q   <= 1'b0;
      cv_q    <= 1'b0;
      vd_q    <= 1'b0;
      ocup_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      rs_q    <= rs_d;
      set_q   <= set_d;
      cv_q    <= cv_d;
      vd_q    <= vd_d;
      ocup_q  <= ocup_d;
      err_q   <= err_d;
    end
  end

  assign selector     = sel_q;
  assign rs           = rs_q;
  assign set          = set_q;
  assign canal_valido = cv_q;
  assign vuelta_done  = vd_q;
  assign ocupado      = ocup_q;
  assign err_mask     = err_q;

endmodule

// File: tb/tb_secuenciador_mux.sv
// Directed bench for secuenciador_mux: scan ordering, dwell timing, force override, stop and reset.
module tb_secuenciador_mux;

  logic       clk = 1'b0;
  logic       reset, start, stop, cmd_clr, cmd_set;
  logic [3:0] mascara;
  logic [3:0] dwell;
  logic [1:0] selector;
  logic       rs, set, canal_valido, vuelta_done, ocupado, err_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  secuenciador_mux #(.DWELL_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .mascara      (mascara),
    .dwell        (dwell),
    .cmd_clr      (cmd_clr),
    .cmd_set      (cmd_set),
    .selector     (selector),
    .rs           (rs),
    .set          (set),
    .canal_valido (canal_valido),
    .vuelta_done  (vuelta_done),
    .ocupado      (ocupado),
    .err_mask     (err_mask)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; cmd_clr = 1'b0; cmd_set = 1'b0;
    mascara = 4'h0; dwell = 4'd0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({selector, rs, set, ocupado, canal_valido, vuelta_done, err_mask} !== 7'b00_1_0_0_000) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got sel=%0d rs=%b set=%b ocu=%b cv=%b vd=%b err=%b want sel=0 rs=1 others 0",
                 i, selector, rs, set, ocupado, canal_valido, vuelta_done, err_mask);
      end
    end
  endtask

  task automatic test_scan_full();
    logic [1:0] exp_sel [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    logic       exp_cv  [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic       exp_vd  [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    mascara = 4'b1111; dwell = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (selector !== exp_sel[i] || canal_valido !== exp_cv[i] || vuelta_done !== exp_vd[i] ||
          rs !== 1'b0 || ocupado !== 1'b1) begin
        errors++;
        $display("FAIL scan_full cyc%0d got sel=%0d cv=%b vd=%b rs=%b ocu=%b want sel=%0d cv=%b vd=%b rs=0 ocu=1",
                 i, selector, canal_valido, vuelta_done, rs, ocupado, exp_sel[i], exp_cv[i], exp_vd[i]);
      end
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_scan_sparse();
    logic [1:0] exp_sel [6] = '{1, 3, 1, 3, 1, 3};
    logic       exp_vd  [6] = '{0, 0, 1, 0, 1, 0};
    mascara = 4'b1010; dwell = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (selector !== exp_sel[i] || canal_valido !== 1'b1 || vuelta_done !== exp_vd[i]) begin
        errors++;
        $display("FAIL scan_sparse cyc%0d got sel=%0d cv=%b vd=%b want sel=%0d cv=1 vd=%b",
                 i, selector, canal_valido, vuelta_done, exp_sel[i], exp_vd[i]);
      end
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_force();
    logic [1:0] exp_sel [3] = '{1, 1, 2};
    logic       exp_cv  [3] = '{0, 0, 1};
    mascara = 4'b1111; dwell = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    // channel 0 for 3 cycles, then channel 1 at count 3, then count 2
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (selector !== 2'd1) begin
      errors++;
      $display("FAIL force_pre got sel=%0d want sel=1", selector);
    end
    cmd_set = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rs !== 1'b0 || set !== 1'b1 || selector !== 2'd1 || ocupado !== 1'b1 || canal_valido !== 1'b0) begin
        errors++;
        $display("FAIL force_set cyc%0d got rs=%b set=%b sel=%0d ocu=%b cv=%b want rs=0 set=1 sel=1 ocu=1 cv=0",
                 i, rs, set, selector, ocupado, canal_valido);
      end
    end
    cmd_set = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rs !== 1'b0 || set !== 1'b0 || selector !== exp_sel[i] || canal_valido !== exp_cv[i]) begin
        errors++;
        $display("FAIL force_resume cyc%0d got rs=%b set=%b sel=%0d cv=%b want rs=0 set=0 sel=%0d cv=%b",
                 i, rs, set, selector, canal_valido, exp_sel[i], exp_cv[i]);
      end
    end
    cmd_clr = 1'b1; cmd_set = 1'b1;
    tick();
    checks++;
    if (rs !== 1'b1 || set !== 1'b0 || ocupado !== 1'b1 || selector !== 2'd2) begin
      errors++;
      $display("FAIL force_both got rs=%b set=%b ocu=%b sel=%0d want rs=1 set=0 ocu=1 sel=2",
               rs, set, ocupado, selector);
    end
    cmd_clr = 1'b0; cmd_set = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_err_mask();
    mascara = 4'b0000; dwell = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err_mask !== 1'b1 || ocupado !== 1'b0 || rs !== 1'b1) begin
      errors++;
      $display("FAIL err_mask_pulse got err=%b ocu=%b rs=%b want err=1 ocu=0 rs=1", err_mask, ocupado, rs);
    end
    tick();
    checks++;
    if (err_mask !== 1'b0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL err_mask_clear got err=%b ocu=%b want err=0 ocu=0", err_mask, ocupado);
    end
    mascara = 4'b1111; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (ocupado !== 1'b0 || rs !== 1'b1 || canal_valido !== 1'b0 || err_mask !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_idle got ocu=%b rs=%b cv=%b err=%b want ocu=0 rs=1 cv=0 err=0",
               ocupado, rs, canal_valido, err_mask);
    end
  endtask

  task automatic test_stop();
    mascara = 4'b1111; dwell = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (selector !== 2'd2 || ocupado !== 1'b1) begin
      errors++;
      $display("FAIL stop_pre got sel=%0d ocu=%b want sel=2 ocu=1", selector, ocupado);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (rs !== 1'b1 || selector !== 2'd0 || ocupado !== 1'b0 || canal_valido !== 1'b0 || vuelta_done !== 1'b0) begin
      errors++;
      $display("FAIL stop_scan got rs=%b sel=%0d ocu=%b cv=%b vd=%b want rs=1 sel=0 ocu=0 cv=0 vd=0",
               rs, selector, ocupado, canal_valido, vuelta_done);
    end
    // start ignored while busy: a second start must not restart channel 0
    mascara = 4'b0110; dwell = 4'd3; start = 1'b1;
    tick();
    start = 1'b1; mascara = 4'b1111;
    tick();
    start = 1'b0;
    checks++;
    if (selector !== 2'd1 || canal_valido !== 1'b0) begin
      errors++;
      $display("FAIL start_busy got sel=%0d cv=%b want sel=1 cv=0", selector, canal_valido);
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_reset_mid_force();
    mascara = 4'b0100; dwell = 4'd5; start = 1'b1;
    tick();
    start = 1'b0; cmd_clr = 1'b1;
    tick();
    checks++;
    if (rs !== 1'b1 || ocupado !== 1'b1 || selector !== 2'd2) begin
      errors++;
      $display("FAIL force_clr got rs=%b ocu=%b sel=%0d want rs=1 ocu=1 sel=2", rs, ocupado, selector);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; cmd_clr = 1'b0;
    checks++;
    if ({selector, rs, set, ocupado, canal_valido, vuelta_done, err_mask} !== 7'b00_1_0_0_000) begin
      errors++;
      $display("FAIL reset_mid_force got sel=%0d rs=%b set=%b ocu=%b cv=%b vd=%b err=%b want sel=0 rs=1 others 0",
               selector, rs, set, ocupado, canal_valido, vuelta_done, err_mask);
    end
    tick();
    checks++;
    if (ocupado !== 1'b0 || canal_valido !== 1'b0) begin
      errors++;
      $display("FAIL reset_stays_idle got ocu=%b cv=%b want ocu=0 cv=0", ocupado, canal_valido);
    end
  endtask

  initial begin
    test_reset();
    test_scan_full();
    test_scan_sparse();
    test_force();
    test_err_mask();
    test_stop();
    test_reset_mid_force();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
